// File: rtl/apfifo_pkg.sv
// apfifo_pkg: shared state encoding, data width and default widths for the ap_fifo packet engine
package apfifo_pkg;
  localparam int APFIFO_DW = 32;
  localparam int LEN_W_DEF = 16;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {S_HDR, S_DATA, S_TRL} state_t;
endpackage

// File: rtl/apfifo_out_skid.sv
// apfifo_out_skid: 2-entry output buffer; space depends only on registered occupancy
module apfifo_out_skid import apfifo_pkg::*; (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [APFIFO_DW-1:0] din,
  input  logic                 pop,
  output logic                 space,
  output logic                 nonempty,
  output logic [APFIFO_DW-1:0] head
);
  logic [1:0] count;
  logic [APFIFO_DW-1:0] tail;
  assign space = count != 2'd2;
  assign nonempty = count != 2'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      count <= count + 2'(push) - 2'(pop);
      if (push && (count == 2'd0 || (count == 2'd1 && pop))) head <= din;
      else if (pop && count == 2'd2) head <= tail;
      if (push && count == 2'd1 && !pop) tail <= din;
    end
endmodule

// File: rtl/apfifo_packet_engine.sv
// apfifo_packet_engine: echoes header, forwards data words, appends a 32-bit sum trailer
// Define APFIFO_PKT_XOR_EN to XOR data words with cfg_key on output.
module apfifo_packet_engine import apfifo_pkg::*; #(
  parameter int LEN_W = LEN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 ip_clk,
  input  logic                 ip_rst,
  input  logic [APFIFO_DW-1:0] in_r_dout,
  input  logic                 in_r_empty_n,
  output logic                 in_r_read,
  output logic [APFIFO_DW-1:0] out_r_din,
  output logic                 out_r_write,
  input  logic                 out_r_full,
  input  logic [APFIFO_DW-1:0] cfg_key,
  output logic                 busy,
  output logic [CNT_W-1:0]     pkt_count
);
  state_t state;
  logic [LEN_W-1:0] rem, hdr_len;
  logic [APFIFO_DW-1:0] sum, key_mask, push_data;
  logic space, nonempty, push;
`ifdef APFIFO_PKT_XOR_EN
  assign key_mask = cfg_key;
`else
  logic unused_key;
  assign unused_key = ^cfg_key;
  assign key_mask = '0;
`endif
  assign hdr_len = in_r_dout[LEN_W-1:0];
  assign in_r_read = in_r_empty_n & space & (state != S_TRL) & !ip_rst;
  assign push = in_r_read | (state == S_TRL & space);
  assign out_r_write = nonempty & !out_r_full;
  assign busy = (state != S_HDR) | nonempty;
  always_comb push_data = state == S_TRL ? sum : state == S_DATA ? in_r_dout ^ key_mask : in_r_dout;
  apfifo_out_skid u_skid (
    .clk(ip_clk),
    .rst(ip_rst),
    .push(push),
    .din(push_data),
    .pop(out_r_write),
    .space(space),
    .nonempty(nonempty),
    .head(out_r_din)
  );
  // sum always accumulates the raw input word, never the scrambled one
  always_ff @(posedge ip_clk or posedge ip_rst)
    if (ip_rst) begin
      state <= S_HDR;
      rem <= '0;
      sum <= '0;
      pkt_count <= '0;
    end else if (push) begin
      if (state == S_HDR) begin
        rem <= hdr_len;
        sum <= '0;
        state <= hdr_len != '0 ? S_DATA : S_TRL;
      end else if (state == S_DATA) begin
        rem <= rem - LEN_W'(1);
        sum <= sum + in_r_dout;
        state <= rem == LEN_W'(1) ? S_TRL : S_DATA;
      end else begin
        pkt_count <= pkt_count + CNT_W'(1);
        state <= S_HDR;
      end
    end
endmodule

// File: tb/tb_apfifo_packet_engine.sv
// tb_apfifo_packet_engine: directed packets against a queue-based stream model
module tb_apfifo_packet_engine;
  logic ip_clk = 0, ip_rst, in_r_empty_n, out_r_full, stall_en;
  logic [31:0] in_r_dout, cfg_key;
  logic in_r_read, out_r_write, busy;
  logic [31:0] out_r_din;
  logic [15:0] pkt_count;
  logic w_read, w_write, w_busy;
  logic [31:0] w_din;
  logic [2:0] w_pc;
  logic [31:0] in_q[$], exp_q[$], got_q[$], dq[$], lq[$];
  int rd_cyc[$], wr_cyc[$];
  int nvec = 0, nerr = 0, cyc = 0, rd_n = 0, wr_n = 0, trl = 0, occ = 0, pc_model = 0;
  logic rd_s = 0;
  logic [15:0] last_pc = 0;

  always #5 ip_clk = ~ip_clk;

  apfifo_packet_engine dut (
    .ip_clk(ip_clk), .ip_rst(ip_rst), .in_r_dout(in_r_dout), .in_r_empty_n(in_r_empty_n),
    .in_r_read(in_r_read), .out_r_din(out_r_din), .out_r_write(out_r_write),
    .out_r_full(out_r_full), .cfg_key(cfg_key), .busy(busy), .pkt_count(pkt_count)
  );
  apfifo_packet_engine #(.CNT_W(3)) u_wrap (
    .ip_clk(ip_clk), .ip_rst(ip_rst), .in_r_dout(in_r_dout), .in_r_empty_n(in_r_empty_n),
    .in_r_read(w_read), .out_r_din(w_din), .out_r_write(w_write),
    .out_r_full(out_r_full), .cfg_key(cfg_key), .busy(w_busy), .pkt_count(w_pc)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] kx();
`ifdef APFIFO_PKT_XOR_EN
    return cfg_key;
`else
    return 32'h0;
`endif
  endfunction

  task automatic drive();
    in_r_empty_n = in_q.size() != 0;
    in_r_dout = in_q.size() != 0 ? in_q[0] : 32'h0;
  endtask

  task automatic send_pkt(input logic [31:0] hdr);
    logic [31:0] s = 0;
    in_q.push_back(hdr);
    exp_q.push_back(hdr);
    foreach (dq[i]) begin
      in_q.push_back(dq[i]);
      exp_q.push_back(dq[i] ^ kx());
      s += dq[i];
    end
    exp_q.push_back(s);
    pc_model++;
    drive();
  endtask

  task automatic tick();
    @(posedge ip_clk);
    #1;
    if (rd_s && in_q.size() != 0) void'(in_q.pop_front());
    out_r_full = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    drive();
  endtask

  task automatic drain();
    int i = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && i < 3000) begin
      tick();
      i++;
    end
    repeat (3) tick();
    chk("drain_pending", 32'(exp_q.size() + in_q.size()), 32'h0);
  endtask

  task automatic clr();
    got_q.delete();
    rd_cyc.delete();
    wr_cyc.delete();
  endtask

  task automatic chk_got(input string name);
    chk({name, "_len"}, 32'(got_q.size()), 32'(lq.size()));
    foreach (lq[i]) chk($sformatf("%s_w%0d", name, i), i < got_q.size() ? got_q[i] : 32'hx, lq[i]);
  endtask

  // occupancy is derived from stream bookkeeping: words read plus trailers minus words written
  always @(negedge ip_clk) begin
    cyc++;
    if (ip_rst) begin
      rd_n = 0; wr_n = 0; trl = 0; last_pc = 0; rd_s = 0;
    end else begin
      if (pkt_count != last_pc) trl++;
      last_pc = pkt_count;
      occ = rd_n + trl - wr_n;
      chk("skid_occ_ok", 32'(occ >= 0 && occ <= 2 && !(in_r_read && occ == 2)), 32'h1);
      chk("write_when_ready", 32'(out_r_write), 32'(occ > 0 && !out_r_full));
      if (out_r_write) begin
        chk("stream_word", out_r_din, exp_q.size() != 0 ? exp_q.pop_front() : 32'hx);
        got_q.push_back(out_r_din);
        wr_cyc.push_back(cyc);
        wr_n++;
      end
      if (in_r_read) begin
        rd_cyc.push_back(cyc);
        rd_n++;
      end
      rd_s = in_r_read;
    end
  end

  initial begin
    ip_rst = 1; in_r_empty_n = 0; in_r_dout = 0; out_r_full = 0; cfg_key = 0; stall_en = 0;
    #12;
    chk("rst_read", 32'(in_r_read), 0);
    chk("rst_write", 32'(out_r_write), 0);
    chk("rst_din", out_r_din, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pkt_count", 32'(pkt_count), 0);
    @(posedge ip_clk); #1 ip_rst = 0;
    clr();
    dq = '{32'd1, 32'd2, 32'd3};
    send_pkt(32'h0001_0003);
    drain();
    lq = '{32'h0001_0003, 32'd1, 32'd2, 32'd3, 32'd6};
    chk_got("basic");
    chk("basic_latency", 32'(wr_cyc[0] - rd_cyc[0]), 32'd1);
    chk("basic_span", 32'(wr_cyc[4] - rd_cyc[0]), 32'd5);
    chk("basic_pkt_count", 32'(pkt_count), 32'd1);

    dq = '{32'h11, 32'h22};
    in_q.push_back(32'h0000_0004); exp_q.push_back(32'h0000_0004);
    foreach (dq[i]) begin in_q.push_back(dq[i]); exp_q.push_back(dq[i] ^ kx()); end
    drive();
    drain();
    chk("partial_busy", 32'(busy), 32'h1);
    @(posedge ip_clk); #1 ip_rst = 1;
    #1;
    chk("mid_rst_read", 32'(in_r_read), 0);
    chk("mid_rst_write", 32'(out_r_write), 0);
    chk("mid_rst_din", out_r_din, 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_pkt_count", 32'(pkt_count), 0);
    in_q.delete(); exp_q.delete(); pc_model = 0; drive();
    tick(); tick();
    ip_rst = 0;
    clr();
    dq = '{32'hA5};
    send_pkt(32'h0005_0001);
    drain();
    lq = '{32'h0005_0001, 32'hA5, 32'hA5};
    chk_got("after_rst");
    chk("after_rst_pkt_count", 32'(pkt_count), 32'd1);

    clr();
    dq.delete();
    send_pkt(32'h00AB_0000);
    dq = '{32'd7};
    send_pkt(32'h0000_0001);
    drain();
    lq = '{32'h00AB_0000, 32'h0, 32'h0000_0001, 32'd7, 32'd7};
    chk_got("n0");
    chk("n0_next_hdr_gap", 32'(rd_cyc[1] - rd_cyc[0]), 32'd2);

    cfg_key = 32'hFFFF_0000;
    clr();
    dq = '{32'h1234_5678, 32'h0000_0001};
    send_pkt(32'h0000_0002);
    drain();
`ifdef APFIFO_PKT_XOR_EN
    lq = '{32'h0000_0002, 32'hEDCB_5678, 32'hFFFF_0001, 32'h1234_5679};
`else
    lq = '{32'h0000_0002, 32'h1234_5678, 32'h0000_0001, 32'h1234_5679};
`endif
    chk_got("key");

    clr();
    dq = '{32'hFFFF_FFFF, 32'h0000_0002};
    send_pkt(32'h0000_0002);
    drain();
    chk("sum_wrap_trailer", got_q.size() == 4 ? got_q[3] : 32'hx, 32'h0000_0001);
    chk("pkt_count_5", 32'(pkt_count), 32'd5);

    stall_en = 1;
    for (int p = 0; p < 5; p++) begin
      dq.delete();
      for (int j = 0; j < 8; j++) dq.push_back($urandom);
      send_pkt(32'h0000_0008 | (32'(p) << 16));
    end
    drain();
    stall_en = 0;
    tick();
    chk("stall_pkt_count", 32'(pkt_count), 32'(pc_model));
    chk("narrow_count_wrap", 32'(w_pc), 32'(pc_model % 8));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
